cartridge_loader: RTL and testbench
===================================

# cartridge_loader

Sequences the RGBY-ROM cartridge read into program RAM and arbitrates the single RAM port between the loader and the CPU. It packs 2-bit colors from the color detector into 12-bit instruction words (six colors per word, first color in the MSBs) and issues one write per completed word. Once the motion controller finishes the cartridge pass, it hands the port to the CPU instruction fetch and releases the CPU from halt. It sits between `colorDetector`, `motionController`, the program RAM and `cpu`.

## Interface
- `MAX_WORDS`, default 256: writable RAM words. Range 1..256. Writes at index ≥ MAX_WORDS are discarded.
- `clk` in 1: system clock, the 1 MHz divided clock.
- `reset` in 1: asynchronous, active-high.
- `load_start` in 1: 1-cycle pulse that begins a new cartridge read.
- `color_valid` in 1: 1-cycle pulse, `color` valid (detectionComplete).
- `color` in 2: color code from the detector.
- `load_done` in 1: 1-cycle pulse, cartridge pass finished.
- `cpu_addr` in 8: CPU program counter.
- `ram_addr` out 8: RAM address.
- `ram_din` out 12: RAM write data.
- `ram_we` out 1: RAM write enable.
- `cpu_run` out 1: 1 = CPU owns the port and is un-halted.
- `words_loaded` out 8: words committed, saturating at MAX_WORDS.
- `overflow` out 1: sticky; a word was discarded.
- `checksum` out 12: XOR of committed words (see Configuration).

## Operation
- States: IDLE, COLLECT, WRITE, FLUSH, RUN. Reset enters IDLE.
- Reset values: all counters 0; `ram_we`=0; `ram_din`=0; `cpu_run`=0; `words_loaded`=0; `overflow`=0; `checksum`=0.
- **IDLE**
  - `load_start` → COLLECT.
  - Clears the write index, color count, shift buffer, `words_loaded`, `overflow` and `checksum`.
- **COLLECT**
  - On `color_valid`: shift buffer ← {buf[9:0], color}; color count +1.
  - On the 6th color: latch the word into the write-data register, clear the buffer and count, go to WRITE.
- **WRITE** (exactly 1 cycle)
  - `ram_we`=1 with `ram_addr` = write index and `ram_din` = latched word.
  - If index < MAX_WORDS: write the word, index +1, `words_loaded` +1, fold the word into `checksum`.
  - Else: `ram_we` stays 0 and `overflow` ← 1.
  - Next state: FLUSH if a `load_done` is pending, else COLLECT.
  - A `color_valid` arriving during WRITE is accepted into the buffer; no color is ever dropped.
- **load_done** in COLLECT
  - Color count 0 → RUN.
  - Otherwise → FLUSH: left-justify the partial buffer (zero-pad the LSBs), latch it, perform one WRITE cycle, then RUN.
  - Same cycle as `color_valid`: the color is accepted first, then done is processed.
  - Same cycle as the 6th color: the full word is written, then RUN with no extra padded word.
- **RUN**
  - `cpu_run`=1; `ram_addr` = `cpu_addr`.
  - `load_start` → COLLECT with all counters and flags cleared; `cpu_run` drops the next cycle.
- Port mux: `ram_addr` = write index during write cycles, `cpu_addr` in RUN, 0 otherwise. `ram_we` is never 1 in RUN.
- `load_start` in COLLECT, WRITE or FLUSH restarts the load: any in-flight write completes first, then all state clears.

## Timing
- `ram_we` rises in the cycle after the edge that sampled the 6th `color_valid`, and stays high for exactly 1 cycle.
- `ram_addr`, `ram_din` and `ram_we` are registered during loading. In RUN, `ram_addr` is a combinational pass-through of `cpu_addr`.
- `cpu_run` rises 1 cycle after `load_done` when the buffer is empty, or 2 cycles after when a flush is needed.
- Back-to-back `color_valid` on every cycle is supported at full rate.
- The write index wraps never; it saturates at MAX_WORDS.

## Configuration
- `CARTRIDGE_LOADER_CHECKSUM_EN`
  - Defined: `checksum` accumulates the XOR of every committed word and clears on `load_start`.
  - Undefined: `checksum` is tied to 0 and its register is not built.

## Structure
- Shared package `rgby_pkg` holds:
  - color codes: RED=2'b00, GREEN=2'b01, BLUE=2'b10, YELLOW=2'b11;
  - `COLORS_PER_WORD`=6;
  - `WORD_W`=12;
  - `ADDR_W`=8;
  - the state enum.
- One sub-module, `color_packer`: shift buffer, color count, word-ready and partial-flush output. The FSM, arbitration and counters stay in the top.

## Test plan
- **Full word:** `load_start`, then colors 0,1,2,3,0,1 → one `ram_we` pulse at addr 0 with `ram_din`=12'h1B1; `words_loaded`=1.
- **Partial flush:** colors 3,3 then `load_done` → write 12'hF00 at addr 0, then `cpu_run`=1 two cycles after done; `ram_addr` tracks `cpu_addr`=8'h2A.
- **Back-to-back colors:** 12 consecutive `color_valid` of YELLOW → writes 12'hFFF at addr 0 and addr 1; no color lost across the WRITE cycle.
- **Overflow:** MAX_WORDS=2, 18 colors → 2 writes, third write suppressed; `overflow`=1; `words_loaded`=2.
- **Reset mid-operation:** `reset` asserted mid-word (after 3 colors) → all outputs 0 immediately; after release, 6 fresh colors of RED produce 12'h000 at addr 0.
- **Checksum (macro defined):** words 12'h1B1 and 12'hFFF committed → `checksum`=12'hE4E. Macro undefined → `checksum`=0.

Source files
------------

// File: rtl/rgby_pkg.sv
// Shared types and constants for the RGBY cartridge loader: color codes,
// word geometry and the loader state encoding.
package rgby_pkg;

  localparam int unsigned COLOR_W         = 2;
  localparam int unsigned COLORS_PER_WORD = 6;
  localparam int unsigned WORD_W          = 12;
  localparam int unsigned ADDR_W          = 8;
  localparam int unsigned CNT_W           = 3;
  localparam int unsigned IDX_W           = ADDR_W + 1;

  localparam logic [COLOR_W-1:0] RED    = 2'b00;
  localparam logic [COLOR_W-1:0] GREEN  = 2'b01;
  localparam logic [COLOR_W-1:0] BLUE   = 2'b10;
  localparam logic [COLOR_W-1:0] YELLOW = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_FLUSH,
    ST_RUN
  } loader_state_t;

  // Move a partial buffer of n colors up to the MSBs, zero-filling the LSBs.
  function automatic logic [WORD_W-1:0] left_justify(input logic [WORD_W-1:0] b,
                                                     input logic [CNT_W-1:0]  n);
    return WORD_W'(b << (COLOR_W * (COLORS_PER_WORD - 32'(n))));
  endfunction

endpackage

// File: rtl/color_packer.sv
// Packs 2-bit colors into 12-bit words, first color in the MSBs. Exposes the
// word and the left-justified partial word as they stand after this cycle's color.
module color_packer
  import rgby_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_valid,
  input  logic [COLOR_W-1:0] i_color,
  output logic               o_full_c,
  output logic [WORD_W-1:0]  o_word_c,
  output logic               o_partial_c,
  output logic [WORD_W-1:0]  o_flush_word_c
);

  logic [WORD_W-1:0] r_buf;
  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] w_buf_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  always_comb begin
    w_buf_nxt = r_buf;
    w_cnt_nxt = r_cnt;
    if (i_valid) begin
      w_buf_nxt = {r_buf[WORD_W-COLOR_W-1:0], i_color};
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  assign o_full_c       = i_valid && (r_cnt == CNT_W'(COLORS_PER_WORD - 1));
  assign o_word_c       = w_buf_nxt;
  assign o_partial_c    = (w_cnt_nxt != '0);
  assign o_flush_word_c = left_justify(w_buf_nxt, w_cnt_nxt);

  // A completed word is handed off, so the buffer restarts empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (i_clear || o_full_c) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else begin
      r_buf <= w_buf_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/cartridge_loader.sv
// Loads packed cartridge words into program RAM, then hands the RAM port to the CPU.
// Optional checksum register: define CARTRIDGE_LOADER_CHECKSUM_EN.
module cartridge_loader
  import rgby_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_start,
  input  logic               color_valid,
  input  logic [COLOR_W-1:0] color,
  input  logic               load_done,
  input  logic [ADDR_W-1:0]  cpu_addr,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [WORD_W-1:0]  ram_din,
  output logic               ram_we,
  output logic               cpu_run,
  output logic [ADDR_W-1:0]  words_loaded,
  output logic               overflow,
  output logic [WORD_W-1:0]  checksum
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_WORDS);

  loader_state_t     r_state;
  loader_state_t     w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_words;
  logic              r_done_pend;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [WORD_W-1:0] r_din;
  logic              r_we;
  logic              r_cpu_run;
  logic              r_overflow;

  logic              w_clear;
  logic              w_pack_valid;
  logic              w_pack_clr;
  logic              w_latch;
  logic [WORD_W-1:0] w_latch_word;
  logic              w_done_pend_nxt;
  logic              w_commit;
  logic              w_room;
  logic [IDX_W-1:0]  w_idx_after;
  logic              w_room_after;
  logic              w_full;
  logic [WORD_W-1:0] w_word;
  logic              w_partial;
  logic [WORD_W-1:0] w_flush_word;

  assign w_clear      = load_start || (r_state == ST_IDLE);
  assign w_pack_valid = color_valid && ((r_state == ST_COLLECT) || (r_state == ST_WRITE));
  assign w_commit     = (r_state == ST_WRITE) || (r_state == ST_FLUSH);
  assign w_room       = (r_idx < MAX_IDX);
  assign w_idx_after  = r_idx + IDX_W'(w_commit && w_room);
  assign w_room_after = (w_idx_after < MAX_IDX);

  color_packer u_packer (
    .clk            (clk),
    .reset          (reset),
    .i_clear        (w_pack_clr || w_clear),
    .i_valid        (w_pack_valid),
    .i_color        (color),
    .o_full_c       (w_full),
    .o_word_c       (w_word),
    .o_partial_c    (w_partial),
    .o_flush_word_c (w_flush_word)
  );

  // Next state and write-latch control; load_start overrides everything.
  always_comb begin
    w_state_nxt     = r_state;
    w_latch         = 1'b0;
    w_latch_word    = w_word;
    w_pack_clr      = 1'b0;
    w_done_pend_nxt = 1'b0;
    case (r_state)
      ST_IDLE: ;
      ST_COLLECT: begin
        if (w_full) begin
          w_latch         = 1'b1;
          w_state_nxt     = ST_WRITE;
          w_done_pend_nxt = load_done;
        end else if (load_done) begin
          if (w_partial) begin
            w_latch      = 1'b1;
            w_latch_word = w_flush_word;
            w_pack_clr   = 1'b1;
            w_state_nxt  = ST_FLUSH;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_WRITE: begin
        if (r_done_pend || load_done) begin
          if (w_partial) begin
            w_latch      = 1'b1;
            w_latch_word = w_flush_word;
            w_pack_clr   = 1'b1;
            w_state_nxt  = ST_FLUSH;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_state_nxt = ST_COLLECT;
        end
      end
      ST_FLUSH: w_state_nxt = ST_RUN;
      ST_RUN:   ;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (load_start) begin
      w_state_nxt     = ST_COLLECT;
      w_latch         = 1'b0;
      w_pack_clr      = 1'b1;
      w_done_pend_nxt = 1'b0;
    end
  end

  // Write strobe is qualified at entry to the write cycle; bookkeeping commits at its end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_done_pend <= 1'b0;
      r_cpu_run   <= 1'b0;
      r_we        <= 1'b0;
      r_ram_addr  <= '0;
      r_din       <= '0;
      r_idx       <= '0;
      r_words     <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_done_pend <= w_done_pend_nxt;
      r_cpu_run   <= (w_state_nxt == ST_RUN);
      r_we        <= w_latch && w_room_after;
      r_ram_addr  <= w_latch ? w_idx_after[ADDR_W-1:0] : '0;
      if (w_clear) begin
        r_din <= '0;
      end else if (w_latch) begin
        r_din <= w_latch_word;
      end
      if (w_clear) begin
        r_idx      <= '0;
        r_words    <= '0;
        r_overflow <= 1'b0;
      end else if (w_commit) begin
        if (w_room) begin
          r_idx   <= r_idx + IDX_W'(1);
          r_words <= r_words + IDX_W'(1);
        end else begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

`ifdef CARTRIDGE_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] r_checksum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (w_clear) begin
      r_checksum <= '0;
    end else if (w_commit && w_room) begin
      r_checksum <= r_checksum ^ r_din;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign ram_addr     = (r_state == ST_RUN) ? cpu_addr : r_ram_addr;
  assign ram_din      = r_din;
  assign ram_we       = r_we;
  assign cpu_run      = r_cpu_run;
  assign overflow     = r_overflow;
  // A full 256-word load cannot be shown in 8 bits, so the count pins at all-ones.
  assign words_loaded = r_words[ADDR_W] ? '1 : r_words[ADDR_W-1:0];

endmodule

// File: tb/tb_cartridge_loader.sv
// Self-checking bench for cartridge_loader: vector table, timing sequences and
// randomized loads against a word-list model of the cartridge contents.
module tb_cartridge_loader;
  import rgby_pkg::*;

  localparam int unsigned TB_MAX = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_start;
  logic       color_valid;
  logic [1:0] color;
  logic       load_done;
  logic [7:0] cpu_addr;
  logic [7:0] ram_addr;
  logic [11:0] ram_din;
  logic       ram_we;
  logic       cpu_run;
  logic [7:0] words_loaded;
  logic       overflow;
  logic [11:0] checksum;

  int checks = 0;
  int errors = 0;
  logic [7:0]  wa_q[$];
  logic [11:0] wd_q[$];

  cartridge_loader #(.MAX_WORDS(TB_MAX)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .color_valid  (color_valid),
    .color        (color),
    .load_done    (load_done),
    .cpu_addr     (cpu_addr),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_we       (ram_we),
    .cpu_run      (cpu_run),
    .words_loaded (words_loaded),
    .overflow     (overflow),
    .checksum     (checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [47:0] cols;
    int          gap;
    bit          done_same;
    int          exp_nw;
    logic [11:0] e0;
    logic [11:0] e1;
    logic [7:0]  ewl;
    bit          eovf;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && ram_we) begin
      wa_q.push_back(ram_addr);
      wd_q.push_back(ram_din);
      chk("we_during_run", 32'(cpu_run), 32'd0);
    end
  end

  function automatic logic [11:0] model_word(input logic [47:0] cols, input int n, input int k);
    logic [11:0] w = '0;
    logic [47:0] c = cols;
    for (int j = 0; j < 6; j++) begin
      int idx = 6 * k + j;
      logic [1:0] cc = (idx < n) ? c[47 - 2*idx -: 2] : 2'b00;
      w = {w[9:0], cc};
    end
    return w;
  endfunction

  function automatic logic [11:0] exp_csum(input int nw, input logic [11:0] e0, input logic [11:0] e1);
    logic [11:0] r = '0;
`ifdef CARTRIDGE_LOADER_CHECKSUM_EN
    if (nw >= 1) r = r ^ e0;
    if (nw >= 2) r = r ^ e1;
`endif
    return r;
  endfunction

  task automatic send_color(input logic [1:0] c, input bit with_done);
    color       = c;
    color_valid = 1'b1;
    load_done   = with_done;
    step();
    color_valid = 1'b0;
    load_done   = 1'b0;
  endtask

  task automatic start_load(input string tag);
    wa_q.delete();
    wd_q.delete();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk({tag, "_start_cpu_run"}, 32'(cpu_run), 32'd0);
    chk({tag, "_start_words"}, 32'(words_loaded), 32'd0);
    chk({tag, "_start_ovf"}, 32'(overflow), 32'd0);
  endtask

  // gap < 0 picks a random 0..2 idle cycles after each color
  task automatic run_load(input string tag, input int n, input logic [47:0] cols,
                          input int gap, input bit done_same);
    logic [47:0] c = cols;
    start_load(tag);
    for (int i = 0; i < n; i++) begin
      send_color(c[47 - 2*i -: 2], done_same && (i == n - 1));
      repeat ((gap < 0) ? $urandom_range(0, 2) : gap) step();
    end
    if (!(done_same && n > 0)) begin
      load_done = 1'b1;
      step();
      load_done = 1'b0;
    end
  endtask

  task automatic check_result(input string tag, input int exp_nw, input logic [11:0] e0,
                              input logic [11:0] e1, input logic [7:0] ewl, input bit eovf);
    logic [7:0] pc;
    int k = 0;
    while (!cpu_run && k < 10) begin
      step();
      k++;
    end
    chk({tag, "_cpu_run"}, 32'(cpu_run), 32'd1);
    chk({tag, "_nwrites"}, 32'(wa_q.size()), 32'(exp_nw));
    if (exp_nw >= 1 && wa_q.size() >= 1) begin
      chk({tag, "_addr0"}, 32'(wa_q[0]), 32'd0);
      chk({tag, "_data0"}, 32'(wd_q[0]), 32'(e0));
    end
    if (exp_nw >= 2 && wa_q.size() >= 2) begin
      chk({tag, "_addr1"}, 32'(wa_q[1]), 32'd1);
      chk({tag, "_data1"}, 32'(wd_q[1]), 32'(e1));
    end
    chk({tag, "_words"}, 32'(words_loaded), 32'(ewl));
    chk({tag, "_ovf"}, 32'(overflow), 32'(eovf));
    chk({tag, "_csum"}, 32'(checksum), 32'(exp_csum(exp_nw, e0, e1)));
    pc = 8'($urandom);
    cpu_addr = pc;
    #1;
    chk({tag, "_cpu_addr_mux"}, 32'(ram_addr), 32'(pc));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load_start = 1'b0; color_valid = 1'b0; color = '0;
    load_done = 1'b0; cpu_addr = '0;

    tbl[0] = '{6,  48'h1B1000000000, 1, 1'b0, 1, 12'h1B1, 12'h000, 8'd1, 1'b0};
    tbl[1] = '{2,  48'hF00000000000, 0, 1'b0, 1, 12'hF00, 12'h000, 8'd1, 1'b0};
    tbl[2] = '{12, 48'hFFFFFF000000, 0, 1'b0, 2, 12'hFFF, 12'hFFF, 8'd2, 1'b0};
    tbl[3] = '{18, 48'hFFFFFFFFF000, 0, 1'b0, 2, 12'hFFF, 12'hFFF, 8'd2, 1'b1};
    tbl[4] = '{12, 48'h1B1FFF000000, 0, 1'b1, 2, 12'h1B1, 12'hFFF, 8'd2, 1'b0};
    tbl[5] = '{6,  48'h000000000000, 1, 1'b1, 1, 12'h000, 12'h000, 8'd1, 1'b0};
    tbl[6] = '{7,  48'hFFFF00000000, 2, 1'b1, 2, 12'hFFF, 12'hC00, 8'd2, 1'b0};
    tbl[7] = '{13, 48'hFFFFFFC00000, 0, 1'b1, 2, 12'hFFF, 12'hFFF, 8'd2, 1'b1};

    #3;
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_din", 32'(ram_din), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_cpu_run", 32'(cpu_run), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_csum", 32'(checksum), 32'd0);
    step();
    reset = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      run_load($sformatf("vec%0d", i), tbl[i].n, tbl[i].cols, tbl[i].gap, tbl[i].done_same);
      check_result($sformatf("vec%0d", i), tbl[i].exp_nw, tbl[i].e0, tbl[i].e1,
                   tbl[i].ewl, tbl[i].eovf);
    end

    // Write strobe lands one cycle after the 6th color, for exactly one cycle.
    start_load("seqA");
    send_color(RED, 1'b0);   send_color(GREEN, 1'b0); send_color(BLUE, 1'b0);
    send_color(YELLOW, 1'b0); send_color(RED, 1'b0);  send_color(GREEN, 1'b0);
    chk("seqA_we_rise", 32'(ram_we), 32'd1);
    chk("seqA_addr", 32'(ram_addr), 32'd0);
    chk("seqA_din", 32'(ram_din), 32'h1B1);
    step();
    chk("seqA_we_fall", 32'(ram_we), 32'd0);
    chk("seqA_words", 32'(words_loaded), 32'd1);
    load_done = 1'b1;
    step();
    load_done = 1'b0;
    chk("seqA_run_1cyc", 32'(cpu_run), 32'd1);

    // Partial flush: padded write cycle, then RUN two cycles after done.
    start_load("seqB");
    send_color(YELLOW, 1'b0);
    send_color(YELLOW, 1'b0);
    load_done = 1'b1;
    step();
    load_done = 1'b0;
    chk("seqB_flush_run", 32'(cpu_run), 32'd0);
    chk("seqB_flush_we", 32'(ram_we), 32'd1);
    chk("seqB_flush_din", 32'(ram_din), 32'hF00);
    chk("seqB_flush_addr", 32'(ram_addr), 32'd0);
    step();
    chk("seqB_run_2cyc", 32'(cpu_run), 32'd1);
    cpu_addr = 8'h2A;
    #1;
    chk("seqB_addr_2a", 32'(ram_addr), 32'h2A);
    chk("seqB_we_run", 32'(ram_we), 32'd0);

    // Reset mid-word after one committed word clears everything at once.
    start_load("seqC");
    for (int i = 0; i < 9; i++) send_color(BLUE, 1'b0);
    reset = 1'b1;
    #2;
    chk("seqC_rst_we", 32'(ram_we), 32'd0);
    chk("seqC_rst_din", 32'(ram_din), 32'd0);
    chk("seqC_rst_addr", 32'(ram_addr), 32'd0);
    chk("seqC_rst_words", 32'(words_loaded), 32'd0);
    chk("seqC_rst_ovf", 32'(overflow), 32'd0);
    chk("seqC_rst_csum", 32'(checksum), 32'd0);
    chk("seqC_rst_cpu_run", 32'(cpu_run), 32'd0);
    step();
    reset = 1'b0;
    step();
    run_load("seqC_fresh", 6, 48'h0, 0, 1'b0);
    check_result("seqC_fresh", 1, 12'h000, 12'h000, 8'd1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int n = $urandom_range(0, 20);
      logic [47:0] cols = {16'($urandom), $urandom};
      bit ds = (n > 0) && ($urandom_range(0, 1) == 1);
      int nw_total = (n + 5) / 6;
      int exp_nw = (nw_total > int'(TB_MAX)) ? int'(TB_MAX) : nw_total;
      run_load($sformatf("rnd%0d", t), n, cols, -1, ds);
      check_result($sformatf("rnd%0d", t), exp_nw, model_word(cols, n, 0),
                   model_word(cols, n, 1), 8'(exp_nw), nw_total > int'(TB_MAX));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
